// File: rtl/bin_gray_counter.sv
// bin_gray_counter: registered binary counter with a registered Gray-code
// copy of the count and a one-cycle rollover pulse.
//
// Ports:
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset (clears bin, gray, wrap)
//   clr       synchronous clear (highest priority)
//   load      synchronous load of load_bin (beats en)
//   load_bin  W-bit binary value to load
//   en        count enable, one step per cycle
//   up        direction, 1 = up, 0 = down (only with macro below)
//   bin       registered binary count
//   gray      registered Gray code of bin
//   wrap      registered pulse on a counted rollover
//
// Macro BIN_GRAY_COUNTER_UPDOWN_EN: when defined, up is honoured and
// the counter counts both ways; otherwise it counts up only and up is
// ignored.

module bin_gray_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         load,
    input  logic [W-1:0] load_bin,
    input  logic         en,
    input  logic         up,
    output logic [W-1:0] bin,
    output logic [W-1:0] gray,
    output logic         wrap
);

    logic [W-1:0] next_bin;
    logic         next_wrap;

`ifdef BIN_GRAY_COUNTER_UPDOWN_EN
    always_comb begin
        next_bin  = bin;
        next_wrap = 1'b0;
        priority case (1'b1)
            clr: begin
                next_bin = '0;
            end
            load: begin
                next_bin = load_bin;
            end
            en: begin
                if (up) begin
                    next_bin  = bin + 1'b1;
                    next_wrap = (bin == {W{1'b1}});
                end else begin
                    next_bin  = bin - 1'b1;
                    next_wrap = (bin == '0);
                end
            end
            default: begin
                next_bin = bin;
            end
        endcase
    end
`else
    // Direction input has no effect in the up-only build.
    logic unused_up;
    assign unused_up = up;

    always_comb begin
        next_bin  = bin;
        next_wrap = 1'b0;
        priority case (1'b1)
            clr: begin
                next_bin = '0;
            end
            load: begin
                next_bin = load_bin;
            end
            en: begin
                next_bin  = bin + 1'b1;
                next_wrap = (bin == {W{1'b1}});
            end
            default: begin
                next_bin = bin;
            end
        endcase
    end
`endif

    // Gray is derived from next_bin so both registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bin  <= '0;
            gray <= '0;
            wrap <= 1'b0;
        end else begin
            bin  <= next_bin;
            gray <= next_bin ^ (next_bin >> 1);
            wrap <= next_wrap;
        end
    end

endmodule

// File: tb/tb_bin_gray_counter.sv
// tb_bin_gray_counter: directed bench for bin_gray_counter (W = 4) with
// an arithmetic reference model checked on every falling clock edge.

module tb_bin_gray_counter;

    localparam int W = 4;
    localparam int M = 2 ** W;

`ifdef BIN_GRAY_COUNTER_UPDOWN_EN
    localparam bit UPDN = 1'b1;
`else
    localparam bit UPDN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         clr = 1'b0;
    logic         load = 1'b0;
    logic [W-1:0] load_bin = '0;
    logic         en = 1'b0;
    logic         up = 1'b1;
    logic [W-1:0] bin;
    logic [W-1:0] gray;
    logic         wrap;

    bin_gray_counter #(.W(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (clr),
        .load     (load),
        .load_bin (load_bin),
        .en       (en),
        .up       (up),
        .bin      (bin),
        .gray     (gray),
        .wrap     (wrap)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    bit chk_on = 1'b0;

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     nm, act, exp, $time);
        end
    endtask

    function automatic int gray_of(input int b);
        return b ^ (b >> 1);
    endfunction

    // Gray-to-binary decoder: each binary bit is the XOR of all
    // Gray bits at or above it.
    function automatic int g2b(input logic [W-1:0] g);
        int acc;
        int b;
        acc = 0;
        b = 0;
        for (int i = W - 1; i >= 0; i--) begin
            acc = acc ^ int'(g[i]);
            b = b | (acc << i);
        end
        return b;
    endfunction

    // Reference model in plain integer arithmetic.
    int m_bin = 0;
    bit m_wrap = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_bin  = 0;
            m_wrap = 1'b0;
        end else begin
            m_wrap = 1'b0;
            if (clr) begin
                m_bin = 0;
            end else if (load) begin
                m_bin = int'(load_bin);
            end else if (en) begin
                if (up || !UPDN) begin
                    if (m_bin == M - 1) m_wrap = 1'b1;
                    m_bin = (m_bin + 1) % M;
                end else begin
                    if (m_bin == 0) m_wrap = 1'b1;
                    m_bin = (m_bin + M - 1) % M;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            chk("bin", int'(bin), m_bin);
            chk("gray", int'(gray), gray_of(m_bin));
            chk("wrap", int'(wrap), int'(m_wrap));
            chk("decode", g2b(gray), m_bin);
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    logic [W-1:0] tab [16];
    logic [W-1:0] prev;
    int nwrap;

    initial begin
        tab = '{4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4, 4'hC,
                4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8, 4'h0};
        chk_on = 1'b1;

        // Reset held low, released mid-cycle.
        en = 1'b1;
        tick;
        tick;
        chk("rst_bin", int'(bin), 0);
        chk("rst_gray", int'(gray), 0);
        chk("rst_wrap", int'(wrap), 0);
        en = 1'b0;
        #3 rst_n = 1'b1;
        tick;
        chk("rel_bin", int'(bin), 0);
        chk("rel_gray", int'(gray), 0);

        // Up count through a full rollover.
        en = 1'b1;
        up = 1'b1;
        prev = gray;
        for (int k = 0; k < 16; k++) begin
            tick;
            chk("up_gray", int'(gray), int'(tab[k]));
            chk("up_hd", $countones(gray ^ prev), 1);
            chk("up_wrap", int'(wrap), (k == 15) ? 1 : 0);
            prev = gray;
        end
        en = 1'b0;
        tick;
        chk("hold_wrap", int'(wrap), 0);
        chk("hold_bin", int'(bin), 0);

`ifdef BIN_GRAY_COUNTER_UPDOWN_EN
        // Down count through 0.
        load_bin = 4'b0001;
        load = 1'b1;
        tick;
        chk("dn_ld_gray", int'(gray), 1);
        load = 1'b0;
        en = 1'b1;
        up = 1'b0;
        tick;
        chk("dn_bin0", int'(bin), 0);
        chk("dn_gray0", int'(gray), 0);
        chk("dn_wrap0", int'(wrap), 0);
        tick;
        chk("dn_bin1", int'(bin), 15);
        chk("dn_gray1", int'(gray), 8);
        chk("dn_wrap1", int'(wrap), 1);
        up = 1'b1;
        tick;
        chk("dir_bin", int'(bin), 0);
        chk("dir_wrap", int'(wrap), 1);
`else
        // Up-only build ignores up = 0.
        load_bin = 4'b0101;
        load = 1'b1;
        tick;
        load = 1'b0;
        en = 1'b1;
        up = 1'b0;
        tick;
        chk("uo_bin", int'(bin), 6);
        chk("uo_gray", int'(gray), 5);
        up = 1'b1;
`endif
        en = 1'b0;

        // Load beats en, and never raises wrap.
        load_bin = 4'b1111;
        load = 1'b1;
        en = 1'b1;
        tick;
        chk("pri_bin", int'(bin), 15);
        chk("pri_gray", int'(gray), 8);
        chk("pri_wrap", int'(wrap), 0);
        clr = 1'b1;
        load_bin = 4'b0111;
        tick;
        chk("clr_bin", int'(bin), 0);
        chk("clr_gray", int'(gray), 0);
        clr = 1'b0;
        load = 1'b0;

        // Continuous count: two rollovers in 2 * 2^W cycles.
        nwrap = 0;
        for (int k = 0; k < 2 * M; k++) begin
            tick;
            if (wrap) nwrap++;
        end
        chk("wrap_cnt", nwrap, 2);

        // Asynchronous reset mid-count.
        tick;
        #2 rst_n = 1'b0;
        #1;
        chk("arst_bin", int'(bin), 0);
        chk("arst_gray", int'(gray), 0);
        chk("arst_wrap", int'(wrap), 0);
        #4 rst_n = 1'b1;
        tick;
        chk("arst_post", int'(bin), 1);
        en = 1'b0;
        tick;

        chk_on = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/bin_gray_counter.md
# bin_gray_counter

Registered binary counter that encodes its count to Gray code every cycle: the encoder-side companion of the 4-bit Gray-to-binary decoder. It supplies glitch-free Gray pointers (one bit change per step) for clock-domain crossing, e.g. async FIFO read and write pointers. The far-side logic recovers binary with the existing decoder. Both outputs come straight from flops, with no combinational path from inputs to outputs.

## Interface
- W, default 4: counter and code width; legal values are 2..16.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- clr  input  1  synchronous clear to zero.
- load  input  1  synchronous load of load_bin.
- load_bin  input  W  binary value to load.
- en  input  1  count enable; one step per cycle while high.
- up  input  1  direction: 1 counts up, 0 counts down (see Configuration).
- bin  output  W  registered binary count.
- gray  output  W  registered Gray code of bin: gray = bin ^ (bin >> 1).
- wrap  output  1  registered one-cycle pulse on rollover.

## Operation
- Reset (rst_n low, asynchronous): bin = 0, gray = 0, wrap = 0, held while rst_n is low. The first update happens on the first rising clk edge after rst_n deasserts.
- Priority per edge: clr > load > en > hold.
- clr: bin <- 0, gray <- 0, wrap <- 0.
- load: bin <- load_bin, gray <- load_bin ^ (load_bin >> 1), wrap <- 0. A load never asserts wrap, even when the loaded value equals a wrap target.
- en with up = 1: bin <- bin + 1, modulo 2^W.
- en with up = 0: bin <- bin - 1, modulo 2^W.
- Each count step changes exactly one bit of gray.
- Hold (none of clr, load, en asserted): bin and gray keep their values; wrap <- 0.
- The Gray value is computed from next_bin and registered in the same edge as bin. gray and bin are never out of step.
- wrap <- 1 only on a counted step in either of these cases:
  - up, from all-ones to 0;
  - down, from 0 to all-ones.
- wrap is 0 on every other edge.
- Arithmetic is unsigned W-bit. Carry and borrow are discarded apart from driving wrap.

## Timing
- Latency: 1 cycle. Inputs sampled at edge N appear on bin, gray and wrap after edge N.
- wrap is high for exactly one cycle per rollover. With en held continuously, wrap pulses every 2^W cycles.
- Simultaneous clr and load: clr wins.
- Simultaneous load and en: load wins and no step is taken.
- Changing up while en is high takes effect on the next edge. There is no dead cycle.
- Reset asserted mid-count clears all outputs immediately, without waiting for a clock edge.

## Configuration
- Macro: BIN_GRAY_COUNTER_UPDOWN_EN.
- Defined: the up port is honoured and the counter counts in both directions, as described above.
- Undefined:
  - The port list is unchanged; up is ignored and the counter counts up only.
  - The decrement logic and the down-wrap detection are not synthesised.

## Test plan
All scenarios use W = 4, with the macro defined unless noted.
- Reset: hold rst_n low, then release it mid-cycle → bin = 0000, gray = 0000, wrap = 0 while low and on the first edge after release.
- Up count with wrap: en = 1, up = 1 for 17 cycles → gray follows 0000, 0001, 0011, 0010, 0110, … 1000, 0000. Each step has a Hamming distance of 1 from the previous value, and wrap pulses once on the 1111→0000 step.
- Down count with wrap: load_bin = 0001, load, then en = 1, up = 0:
  - bin 0001 → 0000 → 1111, gray 0001 → 0000 → 1000;
  - wrap pulses on the 0000→1111 step.
- Priority and load: load = 1, load_bin = 1111, en = 1 → bin = 1111, gray = 1000, wrap = 0. Then clr = 1 together with load = 1 → bin = 0000.
- Decoder round-trip: drive gray into the existing Gray-to-binary decoder over all 16 codes → the decoded value equals bin on every cycle.
- Up-only build (macro undefined): en = 1, up = 0 from bin = 0101 → bin = 0110; the counter still counts up.
